matrix_mult_seq: RTL
====================

// Module: matrix_mult_seq
// PURPOSE
//  Parametrised NxN matrix multiplier, C = A x B, replacing the fixed 2x2 multiplier.
//  Operands load one element per cycle through a select/value port.
//  A single MAC computes C sequentially, one product per cycle, under a start/busy/done handshake.
//  Results are read back per element through a select port.
// PARAMETERS
//  N        2   matrix dimension (>=2)
//  DATA_W   8   operand element width
//  SIGNED   0   0: unsigned operands; 1: two's-complement operands and result
//  ACC_W    2*DATA_W+$clog2(N)   result width (derived, not overridden; 17 for defaults)
// PORTS
//  clk       in   1                       clock, all state on rising edge
//  reset     in   1                       asynchronous, active-low reset
//  load_en   in   1                       write load_val into operand slot load_sel
//  load_sel  in   $clog2(2*N*N)           0..N*N-1 = A row-major; N*N..2*N*N-1 = B row-major
//  load_val  in   DATA_W                  operand value
//  start     in   1                       begin computation (sampled in IDLE only)
//  busy      out  1                       high while computing
//  done      out  1                       one-cycle pulse when C is complete
//  rd_sel    in   $clog2(N*N)             C element index, row-major
//  result    out  ACC_W                   registered C[rd_sel]
// BEHAVIOUR
//  Reset (reset=0): operand regs, C regs, accumulator, indices and result all clear to 0.
//   busy=0, done=0, FSM=IDLE.
//  Reset mid-computation aborts immediately; no partial C survives.
//  FSM
//   IDLE:    start=1 -> COMPUTE. Clear i,j,k, accumulator and all C entries.
//   COMPUTE: each cycle acc += A[i][k]*B[k][j]. Index order: k inner, j middle, i outer.
//            At k=N-1 write C[i][j] = acc + product, zero acc, advance j, then i.
//            After the last element (i=j=k=N-1) -> FIN.
//   FIN:     done=1 for exactly one cycle -> IDLE.
//  Latency: start sampled at edge t. busy=1 for cycles t+1..t+N^3. done=1 in cycle t+N^3+1.
//   busy=0 during that done cycle.
//  load_en while busy or in FIN: write ignored; operands are frozen during compute.
//  load_en and start in the same IDLE cycle: the write lands.
//   The computation uses the new value, because the first MAC happens the next cycle.
//  start while busy/FIN: ignored, not queued.
//  load_sel >= 2*N*N (non-power-of-2 N): write dropped.
//  Arithmetic
//   Products are 2*DATA_W wide. Sign- or zero-extension follows SIGNED.
//   Accumulation is in ACC_W, which is sized so overflow cannot occur.
//  result: registered read, 1-cycle latency from rd_sel.
//   rd_sel >= N*N returns 0.
//   During COMPUTE, not-yet-written entries read 0 and finished entries read their final value.
//  C holds its values after done until the next start or reset.
// STRUCTURE
//  Package matrix_pkg:
//   - state enum {IDLE, COMPUTE, FIN}
//   - function acc_width(N, DATA_W)
//   - helpers for A/B slot base offsets
//  Sub-module mac_unit: parameters DATA_W, ACC_W, SIGNED.
//   - Inputs: clr, en, a, b. Output: acc.
//   - Holds the accumulator register. Gives one multiply-add per cycle.
//  Top level holds the operand/C register arrays, the index counters, the FSM and the result mux.
// TESTING (N=2, DATA_W=8 unless noted)
//  1. Basic multiply.
//     Load A=[1 2;0 3] (sel 0-3) and B=[3 1;2 1] (sel 4-7), then pulse start.
//     -> busy high 8 cycles, done pulse in cycle 9; rd_sel 0..3 -> 7, 3, 6, 3.
//  2. Unsigned maximum.
//     All operands 255, SIGNED=0.
//     -> every C element = 130050 (17-bit), no wrap.
//  3. Signed operation.
//     SIGNED=1, A=[-128 -128;1 -1], B=[-128 0;-128 2].
//     -> C = 32768, -256, 0, -2.
//  4. Frozen operands and ignored start.
//     Attempt to load A[0]=9 mid-compute, and pulse start mid-compute.
//     -> result unchanged from scenario 1; single done pulse; no second run.
//  5. Abort and reads after reset.
//     Assert reset for 1 cycle during COMPUTE.
//     -> busy=0, done=0, all C reads 0. A fresh load+start then gives the correct result.
//  6. Larger matrix, N=3.
//     A = identity, B = 1..9.
//     -> busy 27 cycles; C = 1..9. rd_sel=9..15 (out of range) reads 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and sizing helpers for the sequential matrix multiplier
//  state_t     FSM encoding (IDLE, COMPUTE, FIN)
//  acc_width   result width that cannot overflow for an N-term dot product
//  a_base/b_base  first load slot of the A and B operand regions
package matrix_pkg;

    typedef enum logic [1:0] {IDLE, COMPUTE, FIN} state_t;

    function automatic int acc_width(int n, int dw);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int a_base();
        return 0;
    endfunction

    function automatic int b_base(int n);
        return n * n;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// mac_unit: single multiply-accumulate stage, one product per cycle
//  clk, reset(active-low async)  clock / reset
//  clr    zero the accumulator (wins over en)
//  en     fold the current product into the accumulator
//  a, b   operand elements
//  acc    running sum including the current product (what the next edge would store)
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 17,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0]           acc_r;
    logic [2*DATA_W-1:0]        prod_u;
    logic signed [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0]        prod;

    // operands widened explicitly so both multiplies are full 2*DATA_W wide
    assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign prod   = (SIGNED != 0) ? prod_s : prod_u;
    assign acc    = acc_r + {{(ACC_W-2*DATA_W){(SIGNED != 0) & prod[2*DATA_W-1]}}, prod};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            acc_r <= '0;
        else if (clr)
            acc_r <= '0;
        else if (en)
            acc_r <= acc;
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: NxN matrix multiplier C = A x B using one shared MAC
//  clk, reset(active-low async)   clock / reset
//  load_en, load_sel, load_val    operand write (A slots first, then B, row-major)
//  start, busy, done              run handshake; done is a one-cycle pulse
//  rd_sel, result                 registered read of C[rd_sel], 0 when out of range
module matrix_mult_seq
    import matrix_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int SIGNED = 0,
    localparam int ACC_W = acc_width(N, DATA_W),
    localparam int NN    = N * N,
    localparam int SEL_W = $clog2(2 * NN),
    localparam int RD_W  = $clog2(NN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [SEL_W-1:0]  load_sel,
    input  logic [DATA_W-1:0] load_val,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [RD_W-1:0]   rd_sel,
    output logic [ACC_W-1:0]  result
);

    localparam int IW = $clog2(N);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] a_m [NN];
    logic [DATA_W-1:0] b_m [NN];
    logic [ACC_W-1:0]  c_m [NN];
    logic [IW-1:0]     i, j, k;
    logic              i_last, j_last, k_last, go, mac_clr;
    logic [RD_W-1:0]   a_idx, b_idx, c_idx;
    logic [ACC_W-1:0]  mac_acc;
    logic [SEL_W:0]    sel_x;
    logic [RD_W:0]     rd_x;

    assign i_last  = i == IW'(N - 1);
    assign j_last  = j == IW'(N - 1);
    assign k_last  = k == IW'(N - 1);
    assign go      = state == IDLE && start;
    assign a_idx   = RD_W'(i) * RD_W'(N) + RD_W'(k);
    assign b_idx   = RD_W'(k) * RD_W'(N) + RD_W'(j);
    assign c_idx   = RD_W'(i) * RD_W'(N) + RD_W'(j);
    assign mac_clr = go || (busy && k_last);
    // zero-extended copies keep the range compares meaningful for power-of-2 sizes
    assign sel_x   = {1'b0, load_sel};
    assign rd_x    = {1'b0, rd_sel};

    mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (busy),
        .a     (a_m[a_idx]),
        .b     (b_m[b_idx]),
        .acc   (mac_acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = state == COMPUTE;
        done      = state == FIN;
        case (state)
            IDLE:    state_nxt = start ? COMPUTE : IDLE;
            COMPUTE: state_nxt = (i_last && j_last && k_last) ? FIN : COMPUTE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i      <= '0;
            j      <= '0;
            k      <= '0;
            result <= '0;
            for (int m = 0; m < NN; m++) begin
                a_m[m] <= '0;
                b_m[m] <= '0;
                c_m[m] <= '0;
            end
        end else begin
            // operands only change in IDLE; a write alongside start still lands
            if (load_en && state == IDLE) begin
                if (sel_x < (SEL_W+1)'(b_base(N)))
                    a_m[RD_W'(load_sel - SEL_W'(a_base()))] <= load_val;
                else if (sel_x < (SEL_W+1)'(2 * NN))
                    b_m[RD_W'(load_sel - SEL_W'(b_base(N)))] <= load_val;
            end
            if (go) begin
                i <= '0;
                j <= '0;
                k <= '0;
                for (int m = 0; m < NN; m++)
                    c_m[m] <= '0;
            end
            if (busy) begin
                k <= k_last ? '0 : k + IW'(1);
                if (k_last) begin
                    c_m[c_idx] <= mac_acc;
                    j <= j_last ? '0 : j + IW'(1);
                    if (j_last)
                        i <= i + IW'(1);
                end
            end
            result <= (rd_x < (RD_W+1)'(NN)) ? c_m[rd_sel] : '0;
        end
    end

endmodule
